// File: rtl/seq_mult.sv
// Sequential shift-and-add unsigned multiplier: one multiplier bit per clock,
// WIDTH iterations per product, registered product with a one-cycle done pulse.
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     MR_in,
    input  logic [WIDTH-1:0]     MD_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   PP
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] mr;
    logic [WIDTH-1:0] md;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] mr_nxt;
    logic             capture;
    logic             last;

    // The accumulator is one bit wider than the operand so the add carry
    // survives until it is shifted down into A on the same edge.
    assign sum    = a + (mr[0] ? {1'b0, md} : {(WIDTH + 1){1'b0}});
    assign a_nxt  = {1'b0, sum[WIDTH:1]};
    assign mr_nxt = {sum[0], mr[WIDTH-1:1]};

    assign capture = (state == IDLE) && start;
    assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the datapath is a handful of flops, not a memory, so all of it,
    // including PP, is cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a   <= '0;
            mr  <= '0;
            md  <= '0;
            cnt <= '0;
            PP  <= '0;
        end else if (capture) begin
            a   <= '0;
            mr  <= MR_in;
            md  <= MD_in;
            cnt <= '0;
        end else if (state == RUN) begin
            a   <= a_nxt;
            mr  <= mr_nxt;
            cnt <= cnt + 1'b1;
            if (last) PP <= {a_nxt[WIDTH-1:0], mr_nxt};
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=32): scoreboard of expected
// products and done edges, compared whenever the DUT pulses done.
module tb_seq_mult;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH;      // done seen after edge k+WIDTH
    localparam int TPUT  = WIDTH + 2;  // back-to-back spacing

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 done_edge;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [WIDTH-1:0]     MR_in;
    logic [WIDTH-1:0]     MD_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   PP;

    exp_t               q[$];
    int                 edge_cnt;
    int                 n_checks;
    int                 n_fail;
    int                 n_done;
    int                 n_issued;
    logic [2*WIDTH-1:0] last_prod;

    seq_mult #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .MR_in (MR_in),
        .MD_in (MD_in),
        .busy  (busy),
        .done  (done),
        .PP    (PP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] xx;
        logic [2*WIDTH-1:0] yy;
        xx = {{WIDTH{1'b0}}, x};
        yy = {{WIDTH{1'b0}}, y};
        return xx * yy;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] mr, input logic [WIDTH-1:0] md, input int k);
        exp_t e;
        e.prod      = ref_mul(mr, md);
        e.done_edge = k + LAT;
        q.push_back(e);
        n_issued++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && done) begin
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pp", PP, e.prod);
                check("done_edge", edge_cnt, e.done_edge);
                check("busy_in_done", busy, 1);
                last_prod = e.prod;
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after capture edge k.
    task automatic issue(input logic [WIDTH-1:0] mr, input logic [WIDTH-1:0] md, output int k);
        k     = edge_cnt + 1;
        start = 1'b1;
        MR_in = mr;
        MD_in = md;
        push_exp(mr, md, k);
        @(negedge clk);
        start = 1'b0;
        MR_in = $urandom;
        MD_in = $urandom;
    endtask

    // Full operation with latency, busy and PP-stability checks.
    task automatic run_op(input logic [WIDTH-1:0] mr, input logic [WIDTH-1:0] md);
        int k;
        issue(mr, md, k);
        check("busy_run", busy, 1);
        repeat (LAT / 2) @(negedge clk);
        check("pp_hold_mid_run", PP, last_prod);
        check("no_done_mid_run", done, 0);
        repeat (LAT - LAT / 2) @(negedge clk);
        check("done_at_lat", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) ok = 1'b1;
        end
        check("drain", ok, 1);
    endtask

    initial begin
        int k;
        int k0;
        int n;
        int done_before;

        n_checks  = 0;
        n_fail    = 0;
        n_done    = 0;
        n_issued  = 0;
        last_prod = '0;
        rst       = 1'b0;
        start     = 1'b0;
        MR_in     = 32'hDEAD_BEEF;
        MD_in     = 32'hCAFE_F00D;

        // Reset values before any clock edge.
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pp", PP, 0);

        // Release reset with start already high: first edge must be accepted.
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd3, 32'd5);
        check("pp_3x5", PP, 64'd15);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("pp_carry", PP, 64'hFFFF_FFFE_0000_0001);

        run_op(32'd0, 32'h1234_5678);
        check("pp_zero", PP, 64'd0);

        run_op(32'h1234_5678, 32'd0);
        run_op(32'd1, 32'h8000_0001);
        for (int i = 0; i < 4; i++) run_op($urandom, $urandom);

        // Starts at k+5 (RUN) and k+33 (DONE) must be ignored, not queued.
        done_before = n_done;
        issue(32'd1000, 32'd77, k);
        repeat (4) @(negedge clk);
        start = 1'b1; MR_in = 32'd9; MD_in = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT - 5) @(negedge clk);
        check("done_before_ignore", done, 1);
        start = 1'b1; MR_in = 32'd2; MD_in = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("ignored_single_done", n_done - done_before, 1);
        check("pp_ignored_start", PP, 64'd77000);
        check("idle_after_ignore", busy, 0);

        // Reset mid-run: abandon without a done pulse.
        issue(32'd11, 32'd13, k);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        n_issued--;
        last_prod = '0;
        #1;
        check("midrst_pp", PP, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        done_before = n_done;
        repeat (3) @(negedge clk);
        check("midrst_no_done", n_done - done_before, 0);
        rst = 1'b1;
        run_op(32'd7, 32'd9);
        check("pp_7x9", PP, 64'd63);

        // Start held high: captures every TPUT edges with changing operands.
        k0    = edge_cnt + 1;
        n     = 0;
        start = 1'b1;
        for (int c = 0; c <= 2 * TPUT; c++) begin
            MR_in = $urandom;
            MD_in = $urandom;
            if (edge_cnt + 1 == k0 + TPUT * n) begin
                push_exp(MR_in, MD_in, edge_cnt + 1);
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_drain();
        check("b2b_count", n, 3);

        repeat (5) @(negedge clk);
        check("sb_empty", q.size(), 0);
        check("done_total", n_done, n_issued);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port: MR_in  input  WIDTH  multiplier, unsigned.
REQ-006 SHALL have port: MD_in  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port: busy  output  1  high while in RUN or DONE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; PP valid.
REQ-009 SHALL have port: PP  output  2*WIDTH  registered product.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE with start=1 at a rising edge, capture MR_in into a WIDTH-bit register MR, capture MD_in into MD, clear the (WIDTH+1)-bit accumulator A, clear the bit counter and enter RUN.
REQ-012 SHALL ignore MR_in and MD_in at all times other than the capture edge.
REQ-013 SHALL, per RUN edge, form S = A + (MR[0] ? MD : 0) at WIDTH+1 bits, then load {A,MR} with {S,MR} shifted right by one, zero-filling the MSB.
REQ-014 SHALL perform exactly WIDTH RUN iterations, counted by a counter of ceil(log2(WIDTH+1)) bits.
REQ-015 SHALL, on the edge completing iteration WIDTH, load PP with {A[WIDTH-1:0], MR} and enter DONE.
REQ-016 SHALL assert done=1 only in DONE, which lasts exactly one cycle, then return to IDLE unconditionally.
REQ-017 SHALL fix latency: start sampled at edge k gives done high in the cycle after edge k+WIDTH, independent of operand values, zero operands included.
REQ-018 SHALL ignore start while busy=1, including in DONE; an ignored start SHALL NOT be queued.
REQ-019 SHALL accept a new start in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-020 SHALL hold PP stable from the DONE edge until the next DONE edge; PP SHALL NOT show intermediate values.
REQ-021 SHALL never lose a carry out of the accumulator; the product is exact for all unsigned operand pairs.
REQ-022 SHALL drive busy and done from registered state only, with no combinational path from start.

Reset
REQ-023 SHALL, while rst=0 and regardless of the clock, set state=IDLE, busy=0, done=0, PP=0, and clear A, MR, MD and the counter.
REQ-024 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse; after rst returns to 1, the first start begins a fresh operation.
REQ-025 SHALL leave the FSM in IDLE on the first rising edge after reset release; start=1 on that edge SHALL be accepted.

Verification
REQ-026 SHALL test WIDTH=32, MR=3, MD=5, start at edge k -> done=1 in the cycle after edge k+32 only, PP=64'd15, busy=0 afterward.
REQ-027 SHALL test MR=MD=32'hFFFFFFFF -> PP=64'hFFFFFFFE00000001 (carry path).
REQ-028 SHALL test MR=0, MD=32'h12345678 -> PP=0, with the same 33-cycle latency.
REQ-029 SHALL test start pulses with different operands at edges k+5 and k+33 (DONE) -> both ignored; PP equals the result of the operands captured at k; no second done.
REQ-030 SHALL test rst=0 asserted at edge k+10 of an operation -> PP=0, busy=0 immediately, no done; then 7*9 issued after release -> PP=63.
REQ-031 SHALL test back-to-back operation: start held high continuously -> done pulses every 34 cycles, each with the correct product for the operands present at its capture edge.
